// File: rtl/store_merge_unit.sv
// Store path to the unified memory: SB/SH use read-modify-write, SW writes directly.
// Optional macro STORE_MERGE_STATS_EN adds completed-store and fault counters.
module store_merge_unit #(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [2:0]  req_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
`ifdef STORE_MERGE_STATS_EN
  output logic [31:0] stat_stores,
  output logic [31:0] stat_faults,
`endif
  output logic        done,
  output logic        fault
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  localparam logic [2:0] F3Sb = 3'b000;
  localparam logic [2:0] F3Sh = 3'b001;
  localparam logic [2:0] F3Sw = 3'b010;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] data_q, data_d;
  logic        half_q, half_d;
  logic        fault_q, fault_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [2:0]  req_size;
  logic        bad_funct3;
  logic        misaligned;
  logic [32:0] last_byte;
  logic        req_fault;
  logic [31:0] merged;

  // Fault check on the incoming request; 33-bit sum so wrap past 0xFFFFFFFF still faults.
  always_comb begin
    req_size   = 3'd1;
    bad_funct3 = 1'b0;
    misaligned = 1'b0;
    case (req_funct3)
      F3Sb: req_size = 3'd1;
      F3Sh: begin
        req_size   = 3'd2;
        misaligned = req_addr[0];
      end
      F3Sw: begin
        req_size   = 3'd4;
        misaligned = (req_addr[1:0] != 2'b00);
      end
      default: bad_funct3 = 1'b1;
    endcase
    last_byte = {1'b0, req_addr} + {30'b0, req_size} - 33'd1;
    req_fault = bad_funct3 | misaligned | (last_byte >= 33'(MEM_SIZE));
  end

  always_comb begin
    merged = mem_rdata;
    if (half_q) begin
      if (off_q[1]) merged[31:16] = data_q;
      else          merged[15:0]  = data_q;
    end else begin
      merged[{off_q, 3'b000} +: 8] = data_q[7:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    data_d      = data_q;
    half_d      = half_q;
    fault_d     = fault_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          off_d   = req_addr[1:0];
          data_d  = req_data[15:0];
          half_d  = (req_funct3 == F3Sh);
          fault_d = req_fault;
          if (req_fault) begin
            state_d = StDone;
          end else begin
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (req_funct3 == F3Sw) begin
              mem_wdata_d = req_data;
              state_d     = StWrite;
            end else begin
              state_d = StRead;
            end
          end
        end
      end
      StRead: begin
        mem_wdata_d = merged;
        state_d     = StWrite;
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      off_q       <= 2'b00;
      data_q      <= 16'h0;
      half_q      <= 1'b0;
      fault_q     <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      data_q      <= data_d;
      half_q      <= half_d;
      fault_q     <= fault_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Reset gates the write and the done pulse so an interrupted store leaves no trace.
  assign req_ready = (state_q == StIdle);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = (state_q == StWrite) & ~reset;
  assign done      = (state_q == StDone) & ~reset;
  assign fault     = done & fault_q;

`ifdef STORE_MERGE_STATS_EN
  logic [31:0] stat_stores_q, stat_faults_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stores_q <= 32'h0;
      stat_faults_q <= 32'h0;
    end else if (state_q == StDone) begin
      if (fault_q) stat_faults_q <= stat_faults_q + 32'd1;
      else         stat_stores_q <= stat_stores_q + 32'd1;
    end
  end

  assign stat_stores = stat_stores_q;
  assign stat_faults = stat_faults_q;
`endif

endmodule
